// File: rtl/conv_cnt_sequencer_pkg.sv
// Shared control definitions for the conv datapath sequencer and its decoders.
package conv_ctrl_pkg;

  localparam int unsigned CNT_W      = 5;
  localparam int unsigned LAST_CNT   = 24;
  // Decoders take cnt directly as their select code, so their code width tracks CNT_W.
  localparam int unsigned DEC_CODE_W = CNT_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/conv_cnt_sequencer_if.sv
// Control/status bundle between the top-level control FSM and the sequencer.
interface conv_cnt_sequencer_if #(
  parameter int unsigned CNT_W  = conv_ctrl_pkg::CNT_W,
  parameter int unsigned PASS_W = 2
);

  logic              start;
  logic              stall;
  logic              abort;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_valid;
  logic [PASS_W-1:0] pass_idx;
  logic              busy;
  logic              done;

  // Control FSM side: issues commands, observes progress.
  modport master (
    output start, stall, abort,
    input  cnt, cnt_valid, pass_idx, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, stall, abort,
    output cnt, cnt_valid, pass_idx, busy, done
  );

endinterface

// File: rtl/conv_cnt_sequencer_counter.sv
// Modulo counter 0..MAX with synchronous clear; wrap flags the terminal count.
module mod_counter #(
  parameter int unsigned MAX = 24,
  parameter int unsigned W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         wrap
);

  assign wrap = (q == W'(MAX));

  // Count register: clear wins over enable; rolls to 0 after MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= wrap ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/conv_cnt_sequencer.sv
// Step-count sequencer: NUM_PASS passes of cnt 0..LAST_CNT, stall/abort, pipeline drain, done pulse.
module conv_cnt_sequencer #(
  parameter int unsigned CNT_W    = conv_ctrl_pkg::CNT_W,
  parameter int unsigned LAST_CNT = conv_ctrl_pkg::LAST_CNT,
  parameter int unsigned NUM_PASS = 4,
  parameter int unsigned PASS_W   = 2,
  parameter int unsigned PIPE_LAT = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_cnt_sequencer_if.slave ctl
);

  import conv_ctrl_pkg::state_t;
  import conv_ctrl_pkg::IDLE;
  import conv_ctrl_pkg::RUN;
  import conv_ctrl_pkg::DRAIN;
  import conv_ctrl_pkg::DONE;

  localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t              state, state_d;
  logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_d;
  logic                cnt_valid_q, busy_q, done_q;
  logic                cnt_valid_d, busy_d, done_d;

  logic                step_en, pass_en, cnt_clr;
  logic                step_wrap, pass_wrap, job_end;
  logic [CNT_W-1:0]    step_q;
  logic [PASS_W-1:0]   pass_q;

  // Final step of the final pass: cnt must hold LAST_CNT, so the step counter is not
  // allowed to roll over here; the pass counter therefore never wraps either.
  assign job_end = step_wrap & pass_wrap;
  assign step_en = (state == RUN) & ~ctl.stall & ~job_end;
  assign pass_en = step_en & step_wrap;
  assign cnt_clr = ctl.abort | (state == IDLE) | (state == DONE);

  mod_counter #(.MAX(LAST_CNT), .W(CNT_W)) u_step_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (step_en),
    .clr   (cnt_clr),
    .q     (step_q),
    .wrap  (step_wrap)
  );

  mod_counter #(.MAX(NUM_PASS - 1), .W(PASS_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pass_en),
    .clr   (cnt_clr),
    .q     (pass_q),
    .wrap  (pass_wrap)
  );

  // State, drain counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      drain_cnt   <= '0;
      cnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_d;
      drain_cnt   <= drain_cnt_d;
      cnt_valid_q <= cnt_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic; status flags are derived from the next state so they register with it.
  always_comb begin
    state_d     = state;
    drain_cnt_d = drain_cnt;
    case (state)
      IDLE: begin
        if (ctl.start) state_d = RUN;
      end
      RUN: begin
        if (!ctl.stall && job_end) begin
          state_d     = (PIPE_LAT == 0) ? DONE : DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_W'(PIPE_LAT - 1)) state_d = DONE;
        else                                      drain_cnt_d = drain_cnt + 1'b1;
      end
      DONE: begin
        state_d     = IDLE;
        drain_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
    if (ctl.abort) begin
      state_d     = IDLE;
      drain_cnt_d = '0;
    end
    cnt_valid_d = (state_d == RUN) && !((state == RUN) && ctl.stall);
    busy_d      = (state_d == RUN) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
  end

  assign ctl.cnt       = step_q;
  assign ctl.pass_idx  = pass_q;
  assign ctl.cnt_valid = cnt_valid_q;
  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;

endmodule

// File: tb/tb_conv_cnt_sequencer.sv
// Directed bench: single-pass and four-pass jobs, stall, abort, stray starts, async reset.
module tb_conv_cnt_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  conv_cnt_sequencer_if #(.CNT_W(5), .PASS_W(2)) bus_a ();
  conv_cnt_sequencer_if #(.CNT_W(5), .PASS_W(2)) bus_b ();

  conv_cnt_sequencer #(.NUM_PASS(1), .PIPE_LAT(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus_a)
  );

  conv_cnt_sequencer #(.NUM_PASS(4), .PIPE_LAT(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k cycles after the start-sampling edge for a 1-pass, 3-drain job.
  function automatic void exp_a(input int k, output int c, output logic v,
                                output logic b, output logic d);
    c = 0; v = 1'b0; b = 1'b0; d = 1'b0;
    if (k >= 1 && k <= 25) begin c = k - 1; v = 1'b1; b = 1'b1; end
    else if (k >= 26 && k <= 28) begin c = 24; b = 1'b1; end
    else if (k == 29) begin c = 24; d = 1'b1; end
  endfunction

  // Same for a 4-pass, 3-drain job.
  function automatic void exp_b(input int k, output int c, output int p, output logic v,
                                output logic b, output logic d);
    c = 0; p = 0; v = 1'b0; b = 1'b0; d = 1'b0;
    if (k >= 1 && k <= 100) begin c = (k - 1) % 25; p = (k - 1) / 25; v = 1'b1; b = 1'b1; end
    else if (k >= 101 && k <= 103) begin c = 24; p = 3; b = 1'b1; end
    else if (k == 104) begin c = 24; p = 3; d = 1'b1; end
  endfunction

  task automatic check_a(input string t, input int e, input int k);
    int c; logic v, b, d;
    exp_a(k, c, v, b, d);
    check($sformatf("%s cnt e=%0d", t, e),   32'(bus_a.cnt), 32'(c));
    check($sformatf("%s valid e=%0d", t, e), 32'(bus_a.cnt_valid), 32'(v));
    check($sformatf("%s busy e=%0d", t, e),  32'(bus_a.busy), 32'(b));
    check($sformatf("%s done e=%0d", t, e),  32'(bus_a.done), 32'(d));
  endtask

  task automatic check_b(input string t, input int e, input int k);
    int c, p; logic v, b, d;
    exp_b(k, c, p, v, b, d);
    check($sformatf("%s cnt e=%0d", t, e),   32'(bus_b.cnt), 32'(c));
    check($sformatf("%s pass e=%0d", t, e),  32'(bus_b.pass_idx), 32'(p));
    check($sformatf("%s valid e=%0d", t, e), 32'(bus_b.cnt_valid), 32'(v));
    check($sformatf("%s busy e=%0d", t, e),  32'(bus_b.busy), 32'(b));
    check($sformatf("%s done e=%0d", t, e),  32'(bus_b.done), 32'(d));
  endtask

  task automatic check_idle_b(input string t);
    check({t, " cnt"},   32'(bus_b.cnt), 32'd0);
    check({t, " pass"},  32'(bus_b.pass_idx), 32'd0);
    check({t, " valid"}, 32'(bus_b.cnt_valid), 32'd0);
    check({t, " busy"},  32'(bus_b.busy), 32'd0);
    check({t, " done"},  32'(bus_b.done), 32'd0);
  endtask

  initial begin
    int dones;
    int valids;
    bus_a.start = 1'b0; bus_a.stall = 1'b0; bus_a.abort = 1'b0;
    bus_b.start = 1'b0; bus_b.stall = 1'b0; bus_b.abort = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_idle_b("reset_b");
    check_a("reset_a", 0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single-pass job
    bus_a.start = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      tick();
      if (e == 1) bus_a.start = 1'b0;
      check_a("t1", e, e);
      check($sformatf("t1 pass e=%0d", e), 32'(bus_a.pass_idx), 32'd0);
    end

    // Four-pass job
    dones = 0; valids = 0;
    bus_b.start = 1'b1;
    for (int e = 1; e <= 110; e++) begin
      tick();
      if (e == 1) bus_b.start = 1'b0;
      if (bus_b.done === 1'b1) dones++;
      if (bus_b.cnt_valid === 1'b1) valids++;
      check_b("t2", e, e);
    end
    check("t2 valid_count", 32'(valids), 32'd100);
    check("t2 done_count", 32'(dones), 32'd1);

    // Stall for 5 cycles while cnt=7
    bus_b.start = 1'b1;
    for (int e = 1; e <= 112; e++) begin
      tick();
      if (e == 1) bus_b.start = 1'b0;
      if (e >= 9 && e <= 13) begin
        check($sformatf("t3 hold cnt e=%0d", e), 32'(bus_b.cnt), 32'd7);
        check($sformatf("t3 hold valid e=%0d", e), 32'(bus_b.cnt_valid), 32'd0);
        check($sformatf("t3 hold busy e=%0d", e), 32'(bus_b.busy), 32'd1);
      end else begin
        check_b("t3", e, (e <= 8) ? e : e - 5);
      end
      if (e == 8) bus_b.stall = 1'b1;
      if (e == 13) bus_b.stall = 1'b0;
    end

    // Abort at cnt=13, pass 2
    bus_b.start = 1'b1;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (e == 1) bus_b.start = 1'b0;
      check_b("t4", e, e);
    end
    bus_b.abort = 1'b1;
    tick();
    bus_b.abort = 1'b0;
    check_idle_b("t4 abort");
    dones = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (bus_b.done === 1'b1 || bus_b.busy === 1'b1) dones++;
    end
    check("t4 no_done_after_abort", 32'(dones), 32'd0);

    // Abort together with start in IDLE
    bus_b.abort = 1'b1;
    bus_b.start = 1'b1;
    tick();
    bus_b.abort = 1'b0;
    bus_b.start = 1'b0;
    check_idle_b("t4 abort_start");
    tick();
    check_idle_b("t4 abort_start_next");

    // start held through the whole job: next job begins right after DONE
    dones = 0;
    bus_b.start = 1'b1;
    for (int e = 1; e <= 108; e++) begin
      tick();
      if (bus_b.done === 1'b1) dones++;
      check_b("t5a", e, (e <= 105) ? e : e - 105);
    end
    check("t5a done_count", 32'(dones), 32'd1);
    bus_b.start = 1'b0;
    bus_b.abort = 1'b1;
    tick();
    bus_b.abort = 1'b0;
    check_idle_b("t5a cleanup");

    // start during DRAIN is ignored
    bus_a.start = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      tick();
      if (e == 1) bus_a.start = 1'b0;
      if (e == 26) bus_a.start = 1'b1;
      if (e == 27) bus_a.start = 1'b0;
      check_a("t5b", e, e);
    end

    // Asynchronous reset mid-RUN
    bus_b.start = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 1) bus_b.start = 1'b0;
    end
    check_b("t6 pre", 10, 10);
    #3 rst_n = 1'b0;
    #1;
    check_idle_b("t6 async");
    #2 rst_n = 1'b1;
    dones = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (bus_b.done === 1'b1 || bus_b.busy === 1'b1) dones++;
    end
    check("t6 no_done_after_reset", 32'(dones), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
